// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK modulator and its companion frequency analyzer.
package fsk_pkg;

  // Width of the event counters shared with the analyzer side.
  localparam int CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsk_state_t;

  // Number of clock cycles in half a period of the given tone (integer division).
  function automatic int half_period_ticks(input int clock_hz, input int tone_hz);
    return clock_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/fsk_tone_counter.sv
// Half-period counter for the current tone: strobes when the line should toggle.
module fsk_tone_counter
  import fsk_pkg::*;
#(
  parameter int F0_TICKS = 10,
  parameter int F1_TICKS = 5
) (
  input  logic clock,
  input  logic clear,
  input  logic active,
  input  logic tone_sel,
  input  logic restart,
  output logic toggle
);

  localparam logic [CNT_W-1:0] F0_LAST = CNT_W'(F0_TICKS - 1);
  localparam logic [CNT_W-1:0] F1_LAST = CNT_W'(F1_TICKS - 1);

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] tone_last;

  // Select the half-period of the tone for the bit on the line and detect its end.
  always_comb begin
    tone_last = tone_sel ? F1_LAST : F0_LAST;
    toggle    = active && (half_cnt == tone_last);
  end

  // A symbol boundary or a fresh load restarts the count; the toggle strobe is unaffected.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      half_cnt <= '0;
    end else if (restart) begin
      half_cnt <= '0;
    end else if (active) begin
      if (toggle) half_cnt <= '0;
      else        half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_modulator.sv
// Serialises bytes LSB-first into a phase-continuous two-tone square wave.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int DEFAULT_FREQUENCY0 = 9000,
  parameter int DEFAULT_FREQUENCY1 = 11000,
  parameter int CLOCK_FREQUENCY    = 50000000,
  parameter int BIT_TICKS          = 50000
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sample_data,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  // Parameters are expected to give F0_TICKS, F1_TICKS and BIT_TICKS of at least 1.
  localparam int F0_TICKS = half_period_ticks(CLOCK_FREQUENCY, DEFAULT_FREQUENCY0);
  localparam int F1_TICKS = half_period_ticks(CLOCK_FREQUENCY, DEFAULT_FREQUENCY1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TICKS - 1);

  fsk_state_t       state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] bit_cnt;
  logic             active;
  logic             bit_end;
  logic             handshake;
  logic             restart;
  logic             toggle;

  // Handshake decode: ready in IDLE, or on the last cycle of the last bit for gapless streaming.
  always_comb begin
    active     = (state == SEND) && enable;
    bit_end    = (bit_cnt == BIT_LAST);
    data_ready = enable && ((state == IDLE) || ((state == SEND) && (bit_idx == 3'd7) && bit_end));
    handshake  = data_valid && data_ready;
    restart    = ((state == IDLE) && handshake) || (active && bit_end);
  end

  fsk_tone_counter #(
    .F0_TICKS (F0_TICKS),
    .F1_TICKS (F1_TICKS)
  ) u_tone (
    .clock    (clock),
    .clear    (clear),
    .active   (active),
    .tone_sel (shift[0]),
    .restart  (restart),
    .toggle   (toggle)
  );

  // Transmit FSM: word loading, bit timing, line toggling and completed-word count.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      shift       <= '0;
      bit_idx     <= '0;
      bit_cnt     <= '0;
      sample_data <= 1'b0;
      words_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            shift   <= data_in;
            bit_idx <= '0;
            bit_cnt <= '0;
            state   <= SEND;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (toggle) sample_data <= ~sample_data;
            if (bit_end) begin
              bit_cnt <= '0;
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                words_sent <= words_sent + 1'b1;
                if (handshake) begin
                  shift   <= data_in;
                  bit_idx <= '0;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_modulator.sv
// Directed bench for fsk_modulator: F0_TICKS=10, F1_TICKS=5, BIT_TICKS=20.
module tb_fsk_modulator;

  logic        clock;
  logic        clear;
  logic        enable;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        sample_data;
  logic        busy;
  logic [31:0] words_sent;

  int n_checks;
  int n_pass;
  int exp_words;
  int tog[64];
  int ntog;
  int busy_cnt;

  fsk_modulator #(
    .DEFAULT_FREQUENCY0 (50),
    .DEFAULT_FREQUENCY1 (100),
    .CLOCK_FREQUENCY    (1000),
    .BIT_TICKS          (20)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .enable      (enable),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .sample_data (sample_data),
    .busy        (busy),
    .words_sent  (words_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Handshake one word at edge T, then record toggle edges (relative to T) and busy cycles.
  task automatic send_word(input logic [7:0] w, input int nedges);
    logic prev;
    @(negedge clock);
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    prev     = sample_data;
    ntog     = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= nedges; k++) begin
      @(posedge clock);
      #1;
      if (sample_data !== prev) begin
        if (ntog < 64) tog[ntog] = k;
        ntog++;
        prev = sample_data;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    clear      = 1'b0;
    enable     = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    #13;
    n_checks++; if (sample_data !== 1'b0) $display("FAIL reset_sample: got %0b expected 0", sample_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (words_sent !== 32'd0) $display("FAIL reset_words: got %0d expected 0", words_sent); else n_pass++;
    n_checks++; if (data_ready !== 1'b1) $display("FAIL reset_ready_en: got %0b expected 1", data_ready); else n_pass++;
    enable = 1'b0;
    #1;
    n_checks++; if (data_ready !== 1'b0) $display("FAIL reset_ready_dis: got %0b expected 0", data_ready); else n_pass++;
    enable = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    exp_words = 0;
  endtask

  task automatic test_zero_word;
    int bad;
    send_word(8'h00, 170);
    exp_words++;
    bad = 0;
    for (int i = 1; i < 16; i++) if (tog[i] - tog[i-1] != 10) bad++;
    n_checks++; if (ntog != 16) $display("FAIL zero_toggles: got %0d expected 16", ntog); else n_pass++;
    n_checks++; if (tog[0] != 10) $display("FAIL zero_first: got %0d expected 10", tog[0]); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL zero_spacing: got %0d bad gaps expected 0", bad); else n_pass++;
    n_checks++; if (busy_cnt != 160) $display("FAIL zero_busy: got %0d expected 160", busy_cnt); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words)) $display("FAIL zero_words: got %0d expected %0d", words_sent, exp_words); else n_pass++;
    n_checks++; if (sample_data !== 1'b0) $display("FAIL zero_level: got %0b expected 0", sample_data); else n_pass++;
  endtask

  task automatic test_ones_word;
    int bad;
    send_word(8'hFF, 170);
    exp_words++;
    bad = 0;
    for (int i = 1; i < 32; i++) if (tog[i] - tog[i-1] != 5) bad++;
    n_checks++; if (ntog != 32) $display("FAIL ones_toggles: got %0d expected 32", ntog); else n_pass++;
    n_checks++; if (tog[0] != 5) $display("FAIL ones_first: got %0d expected 5", tog[0]); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL ones_spacing: got %0d bad gaps expected 0", bad); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words)) $display("FAIL ones_words: got %0d expected %0d", words_sent, exp_words); else n_pass++;
  endtask

  task automatic test_mixed_word;
    send_word(8'h01, 170);
    exp_words++;
    n_checks++; if (ntog != 18) $display("FAIL mix_toggles: got %0d expected 18", ntog); else n_pass++;
    n_checks++; if (tog[0] != 5) $display("FAIL mix_first: got %0d expected 5", tog[0]); else n_pass++;
    n_checks++; if (tog[3] != 20) $display("FAIL mix_bit0_last: got %0d expected 20", tog[3]); else n_pass++;
    n_checks++; if (tog[4] != 30) $display("FAIL mix_bit1_first: got %0d expected 30", tog[4]); else n_pass++;
    n_checks++; if (tog[17] != 160) $display("FAIL mix_last: got %0d expected 160", tog[17]); else n_pass++;
    n_checks++; if (sample_data !== 1'b0) $display("FAIL mix_level: got %0b expected 0", sample_data); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int hits;
    int at;
    @(negedge clock);
    data_in    = 8'hA5;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_in  = 8'h3C;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    hits = 0;
    at   = -1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clock);
      if (data_ready === 1'b1) begin
        hits++;
        at = k;
      end
      @(posedge clock);
      #1;
      if (busy === 1'b1) busy_cnt++;
    end
    data_valid = 1'b0;
    n_checks++; if (hits != 1) $display("FAIL b2b_ready_count: got %0d expected 1", hits); else n_pass++;
    n_checks++; if (at != 160) $display("FAIL b2b_ready_edge: got %0d expected 160", at); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words + 1)) $display("FAIL b2b_words_mid: got %0d expected %0d", words_sent, exp_words + 1); else n_pass++;
    for (int k = 161; k <= 320; k++) begin
      @(posedge clock);
      #1;
      if (busy === 1'b1) busy_cnt++;
    end
    exp_words += 2;
    n_checks++; if (busy_cnt != 320) $display("FAIL b2b_busy: got %0d expected 320", busy_cnt); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words)) $display("FAIL b2b_words_end: got %0d expected %0d", words_sent, exp_words); else n_pass++;
    n_checks++; if (sample_data !== 1'b0) $display("FAIL b2b_level: got %0b expected 0", sample_data); else n_pass++;
  endtask

  task automatic test_enable_abort;
    int changes;
    @(negedge clock);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clock);
      #1;
    end
    enable = 1'b0;
    #1;
    n_checks++; if (data_ready !== 1'b0) $display("FAIL abort_ready_low: got %0b expected 0", data_ready); else n_pass++;
    n_checks++; if (sample_data !== 1'b1) $display("FAIL abort_level_pre: got %0b expected 1", sample_data); else n_pass++;
    changes = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (sample_data !== 1'b1) changes++;
    end
    n_checks++; if (changes != 0) $display("FAIL abort_frozen: got %0d changed cycles expected 0", changes); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words)) $display("FAIL abort_words: got %0d expected %0d", words_sent, exp_words); else n_pass++;
    n_checks++; if (data_ready !== 1'b0) $display("FAIL abort_ready_idle: got %0b expected 0", data_ready); else n_pass++;
    enable = 1'b1;
    #1;
    n_checks++; if (data_ready !== 1'b1) $display("FAIL abort_ready_back: got %0b expected 1", data_ready); else n_pass++;
  endtask

  task automatic test_clear_midword;
    @(negedge clock);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clock);
      #1;
    end
    n_checks++; if (sample_data !== 1'b1) $display("FAIL clr_level_pre: got %0b expected 1", sample_data); else n_pass++;
    #2;
    clear = 1'b0;
    #1;
    n_checks++; if (sample_data !== 1'b0) $display("FAIL clr_sample: got %0b expected 0", sample_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clr_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (words_sent !== 32'd0) $display("FAIL clr_words: got %0d expected 0", words_sent); else n_pass++;
    #1;
    clear = 1'b1;
    exp_words = 0;
    send_word(8'h00, 170);
    exp_words++;
    n_checks++; if (ntog != 16) $display("FAIL clr_next_toggles: got %0d expected 16", ntog); else n_pass++;
    n_checks++; if (tog[0] != 10) $display("FAIL clr_next_first: got %0d expected 10", tog[0]); else n_pass++;
    n_checks++; if (words_sent !== 32'(exp_words)) $display("FAIL clr_next_words: got %0d expected %0d", words_sent, exp_words); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_words = 0;
    test_reset();
    test_zero_word();
    test_ones_word();
    test_mixed_word();
    test_back_to_back();
    test_enable_abort();
    test_clear_midword();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
